// File: rtl/tt_pkg.sv
// ============================================================================
// Module   : tt_pkg
// Purpose  : Shared state encoding and parameter bounds for the truth-table
//            sweep engine.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package tt_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_APPLY  = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_EMIT   = 3'd3,
        ST_DONE   = 3'd4
    } tt_state_t;

    localparam int c_max_n_in   = 8;
    localparam int c_max_n_out  = 8;
    localparam int c_max_settle = 15;
    localparam int c_settle_w   = 4;

endpackage

`default_nettype wire

// File: rtl/tt_settle_timer.sv
// ============================================================================
// Module   : tt_settle_timer
// Purpose  : Loadable down-counter that flags the last settle cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_settle_timer
    import tt_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [c_settle_w-1:0] load_val,
    input  logic                  dec,
    output logic                  expired
);

    localparam logic [c_settle_w-1:0] c_one  = 1;
    localparam logic [c_settle_w-1:0] c_zero = '0;

    logic [c_settle_w-1:0] count_q;
    logic [c_settle_w-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != c_zero)) begin
            count_d = count_q - c_one;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expiry is flagged on the final held cycle so the caller leaves on that edge.
    assign expired = (count_q <= c_one);

endmodule

`default_nettype wire

// File: rtl/tt_sweeper.sv
// ============================================================================
// Module   : tt_sweeper
// Purpose  : Exhaustive truth-table sweep engine with per-vector record stream.
//            Option macro: TT_SWEEP_STOP_ON_FAIL_EN (end sweep on first mismatch).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tt_sweeper
    import tt_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int N_OUT  = 2,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [N_IN-1:0]  stim,
    input  logic [N_OUT-1:0] dut_y,
    input  logic [N_OUT-1:0] exp_y,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [N_IN-1:0]  rec_idx,
    output logic [N_OUT-1:0] rec_y,
    output logic             rec_mis,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [N_IN:0]    err_count,
    output logic [N_IN-1:0]  first_fail_idx,
    output logic             first_fail_valid
);

    generate
        if (N_IN < 1 || N_IN > c_max_n_in) begin : g_bad_n_in
            $error("tt_sweeper: N_IN out of range");
        end
        if (N_OUT < 1 || N_OUT > c_max_n_out) begin : g_bad_n_out
            $error("tt_sweeper: N_OUT out of range");
        end
        if (SETTLE < 1 || SETTLE > c_max_settle) begin : g_bad_settle
            $error("tt_sweeper: SETTLE out of range");
        end
    endgenerate

    localparam logic [N_IN-1:0]       c_last_idx   = '1;
    localparam logic [N_IN-1:0]       c_stim_one   = 1;
    localparam logic [N_IN:0]         c_err_one    = 1;
    localparam logic [c_settle_w-1:0] c_settle_val = c_settle_w'(SETTLE);

    tt_state_t        state_q, state_d;
    logic [N_IN-1:0]  stim_q, stim_d;
    logic [N_IN-1:0]  rec_idx_q, rec_idx_d;
    logic [N_OUT-1:0] rec_y_q, rec_y_d;
    logic             rec_mis_q, rec_mis_d;
    logic             rec_valid_q, rec_valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [N_IN:0]    err_count_q, err_count_d;
    logic [N_IN-1:0]  ff_idx_q, ff_idx_d;
    logic             ff_valid_q, ff_valid_d;

    logic timer_load;
    logic timer_dec;
    logic timer_expired;
    logic stop_now;
    logic sample_mis;

`ifdef TT_SWEEP_STOP_ON_FAIL_EN
    assign stop_now = rec_mis_q;
`else
    assign stop_now = 1'b0;
`endif

    assign sample_mis = (dut_y != exp_y);

    tt_settle_timer u_settle_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (c_settle_val),
        .dec      (timer_dec),
        .expired  (timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        stim_d      = stim_q;
        rec_idx_d   = rec_idx_q;
        rec_y_d     = rec_y_q;
        rec_mis_d   = rec_mis_q;
        pass_d      = pass_q;
        err_count_d = err_count_q;
        ff_idx_d    = ff_idx_q;
        ff_valid_d  = ff_valid_q;
        timer_load  = 1'b0;
        timer_dec   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_APPLY;
                    stim_d      = '0;
                    err_count_d = '0;
                    ff_idx_d    = '0;
                    ff_valid_d  = 1'b0;
                    pass_d      = 1'b0;
                    timer_load  = 1'b1;
                end
            end
            ST_APPLY: begin
                timer_dec = 1'b1;
                if (timer_expired) begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                rec_idx_d = stim_q;
                rec_y_d   = dut_y;
                rec_mis_d = sample_mis;
                if (sample_mis) begin
                    err_count_d = err_count_q + c_err_one;
                    if (!ff_valid_q) begin
                        ff_idx_d   = stim_q;
                        ff_valid_d = 1'b1;
                    end
                end
                state_d = ST_EMIT;
            end
            ST_EMIT: begin
                if (rec_ready) begin
                    if ((stim_q == c_last_idx) || stop_now) begin
                        state_d = ST_DONE;
                        // Verdict lands with the done pulse; err_count is final here.
                        pass_d  = (err_count_q == '0);
                    end else begin
                        stim_d     = stim_q + c_stim_one;
                        timer_load = 1'b1;
                        state_d    = ST_APPLY;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rec_valid_d = (state_d == ST_EMIT);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            stim_q      <= '0;
            rec_idx_q   <= '0;
            rec_y_q     <= '0;
            rec_mis_q   <= 1'b0;
            rec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= '0;
            ff_idx_q    <= '0;
            ff_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            stim_q      <= stim_d;
            rec_idx_q   <= rec_idx_d;
            rec_y_q     <= rec_y_d;
            rec_mis_q   <= rec_mis_d;
            rec_valid_q <= rec_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_count_q <= err_count_d;
            ff_idx_q    <= ff_idx_d;
            ff_valid_q  <= ff_valid_d;
        end
    end

    assign stim             = stim_q;
    assign rec_valid        = rec_valid_q;
    assign rec_idx          = rec_idx_q;
    assign rec_y            = rec_y_q;
    assign rec_mis          = rec_mis_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_count_q;
    assign first_fail_idx   = ff_idx_q;
    assign first_fail_valid = ff_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_tt_sweeper.sv
// ============================================================================
// Module   : tb_tt_sweeper
// Purpose  : Self-checking bench for tt_sweeper against a table-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tt_sweeper;

    localparam int N_IN    = 4;
    localparam int N_OUT   = 2;
    localparam int SETTLE  = 3;
    localparam int NV      = 1 << N_IN;
    localparam int VEC_CYC = SETTLE + 2;

`ifdef TT_SWEEP_STOP_ON_FAIL_EN
    localparam bit STOP_ON_FAIL = 1'b1;
`else
    localparam bit STOP_ON_FAIL = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             rec_ready;
    logic [N_IN-1:0]  stim;
    logic [N_OUT-1:0] dut_y;
    logic [N_OUT-1:0] exp_y;
    logic             rec_valid;
    logic [N_IN-1:0]  rec_idx;
    logic [N_OUT-1:0] rec_y;
    logic             rec_mis;
    logic             busy;
    logic             done;
    logic             pass;
    logic [N_IN:0]    err_count;
    logic [N_IN-1:0]  first_fail_idx;
    logic             first_fail_valid;

    logic [N_OUT-1:0] dut_tab [NV];
    logic [N_OUT-1:0] exp_tab [NV];

    int checks = 0;
    int errors = 0;

    assign dut_y = dut_tab[stim];
    assign exp_y = exp_tab[stim];

    always #5 clk = ~clk;

    tt_sweeper #(
        .N_IN   (N_IN),
        .N_OUT  (N_OUT),
        .SETTLE (SETTLE)
    ) u_dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .stim             (stim),
        .dut_y            (dut_y),
        .exp_y            (exp_y),
        .rec_valid        (rec_valid),
        .rec_ready        (rec_ready),
        .rec_idx          (rec_idx),
        .rec_y            (rec_y),
        .rec_mis          (rec_mis),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_fail_idx   (first_fail_idx),
        .first_fail_valid (first_fail_valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stim"},  stim, 0);
        check({tag, "_valid"}, rec_valid, 0);
        check({tag, "_idx"},   rec_idx, 0);
        check({tag, "_y"},     rec_y, 0);
        check({tag, "_mis"},   rec_mis, 0);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_pass"},  pass, 0);
        check({tag, "_err"},   err_count, 0);
        check({tag, "_ffi"},   first_fail_idx, 0);
        check({tag, "_ffv"},   first_fail_valid, 0);
    endtask

    // exp_mode: 0 loopback, 1 random mismatches, 2 all mismatching
    task automatic fill_tables(input int exp_mode);
        for (int i = 0; i < NV; i++) begin
            dut_tab[i] = N_OUT'($urandom);
            case (exp_mode)
                0:       exp_tab[i] = dut_tab[i];
                1:       exp_tab[i] = ($urandom_range(0, 3) == 0) ? ~dut_tab[i] : dut_tab[i];
                default: exp_tab[i] = ~dut_tab[i];
            endcase
        end
    endtask

    // ready_mode: 0 always ready, 1 random ready plus random start noise,
    // 2 ready held low for 4 cycles while record 2 is offered
    task automatic run_sweep(input int ready_mode, input string name);
        int n_used, exp_err, exp_ff, edge_n, stalls, rec_n, run_err, run_ff, stall_left;
        bit exp_ffv, run_ffv, seen_done, prev_valid, hs;
        logic [N_IN-1:0] cur_idx;

        n_used  = NV;
        exp_err = 0;
        exp_ffv = 0;
        exp_ff  = 0;
        for (int i = 0; i < NV; i++) begin
            if (dut_tab[i] != exp_tab[i]) begin
                exp_err++;
                if (!exp_ffv) begin
                    exp_ffv = 1;
                    exp_ff  = i;
                end
                if (STOP_ON_FAIL) begin
                    n_used = i + 1;
                    break;
                end
            end
        end

        @(negedge clk);
        start     = 1'b1;
        rec_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({name, "_start_stim"}, stim, 0);
        check({name, "_start_busy"}, busy, 1);
        check({name, "_start_err"},  err_count, 0);
        check({name, "_start_ffv"},  first_fail_valid, 0);
        check({name, "_start_pass"}, pass, 0);

        edge_n     = 0;
        stalls     = 0;
        rec_n      = 0;
        run_err    = 0;
        run_ffv    = 0;
        run_ff     = 0;
        stall_left = 4;
        seen_done  = 0;
        cur_idx    = '0;

        while (!seen_done && edge_n < 2000) begin
            case (ready_mode)
                0: rec_ready = 1'b1;
                1: rec_ready = ($urandom_range(0, 3) != 0);
                default: begin
                    if (rec_valid && rec_n == 2 && stall_left > 0) begin
                        rec_ready = 1'b0;
                        stall_left--;
                    end else begin
                        rec_ready = 1'b1;
                    end
                end
            endcase
            if (ready_mode == 1) start = $urandom_range(0, 1) == 1;
            hs = rec_valid && rec_ready;
            if (rec_valid && !rec_ready) stalls++;
            prev_valid = rec_valid;

            @(posedge clk);
            #1;
            edge_n++;
            if (hs) begin
                rec_n++;
                if (rec_n < n_used) cur_idx = cur_idx + 1'b1;
            end

            check({name, "_stim"}, stim, cur_idx);
            if (rec_valid) begin
                if (!prev_valid) begin
                    check({name, "_rec_time"}, edge_n, rec_n * VEC_CYC + SETTLE + 1 + stalls);
                    if (dut_tab[rec_n] != exp_tab[rec_n]) begin
                        run_err++;
                        if (!run_ffv) begin
                            run_ffv = 1;
                            run_ff  = rec_n;
                        end
                    end
                end
                check({name, "_rec_idx"}, rec_idx, rec_n);
                check({name, "_rec_y"},   rec_y, dut_tab[rec_n]);
                check({name, "_rec_mis"}, rec_mis, dut_tab[rec_n] != exp_tab[rec_n]);
                check({name, "_run_err"}, err_count, run_err);
                check({name, "_run_ffv"}, first_fail_valid, run_ffv);
                if (run_ffv) check({name, "_run_ffi"}, first_fail_idx, run_ff);
            end
            if (done) begin
                seen_done = 1;
                check({name, "_done_time"}, edge_n, n_used * VEC_CYC + stalls);
                check({name, "_done_recs"}, rec_n, n_used);
                check({name, "_pass"},      pass, exp_err == 0);
                check({name, "_err"},       err_count, exp_err);
                check({name, "_ffv"},       first_fail_valid, exp_ffv);
                if (exp_ffv) check({name, "_ffi"}, first_fail_idx, exp_ff);
            end
        end
        start     = 1'b0;
        rec_ready = 1'b1;
        if (!seen_done) check({name, "_done_timeout"}, 0, 1);

        @(posedge clk);
        #1;
        check({name, "_post_done"}, done, 0);
        check({name, "_post_busy"}, busy, 0);
        check({name, "_post_pass"}, pass, exp_err == 0);
    endtask

    initial begin
        int pre_err;

        reset     = 1'b1;
        start     = 1'b0;
        rec_ready = 1'b0;
        fill_tables(0);
        #3;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_busy", busy, 0);

        fill_tables(0);
        run_sweep(0, "loopback");

        fill_tables(0);
        exp_tab[5] = ~dut_tab[5];
        run_sweep(0, "mis5");

        fill_tables(0);
        run_sweep(2, "stall2");

        fill_tables(1);
        run_sweep(1, "rand_a");
        fill_tables(1);
        run_sweep(1, "rand_b");

        fill_tables(2);
        run_sweep(0, "allmis");

        // Abort during APPLY of vector 4 with a mismatch already counted.
        fill_tables(0);
        if (!STOP_ON_FAIL) exp_tab[1] = ~dut_tab[1];
        pre_err = (dut_tab[1] != exp_tab[1]) ? 1 : 0;
        @(negedge clk);
        start     = 1'b1;
        rec_ready = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4 * VEC_CYC) @(posedge clk);
        #1;
        check("abort_pre_stim", stim, 4);
        check("abort_pre_busy", busy, 1);
        check("abort_pre_err",  err_count, pre_err);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("abort_no_done", done, 0);
            check("abort_idle",    busy, 0);
        end

        fill_tables(1);
        run_sweep(0, "restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
